// File: rtl/mock_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : mock_uart_rx
// Description : Memory-mapped mock UART receiver. Host-injected bytes are
//               queued in an RX FIFO that the core drains through a small
//               register window (RXDATA 0x0, STAT 0x8, CTRL 0xC).
//               Optional RX interrupt enabled by macro MOCK_UART_RX_IRQ_EN.
//               FIFO_DEPTH must be a power of two, at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module mock_uart_rx #(
  parameter logic [31:0] BASE_ADDR  = 32'hC000_0000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_DEVICE_strobe,
  input  logic [31:0] M_DEVICE_addr,
  input  logic        M_DEVICE_rw,
  input  logic [3:0]  M_DEVICE_byte_enable,
  input  logic [31:0] M_DEVICE_core2dev_data,
  output logic        M_DEVICE_data_ready,
  output logic [31:0] M_DEVICE_dev2core_data,
  input  logic        host_wr,
  input  logic [7:0]  host_data
`ifdef MOCK_UART_RX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int           AW     = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  c_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]   c_OFF_RXDATA = 4'h0;
  localparam logic [3:0]   c_OFF_STAT   = 4'h8;
  localparam logic [3:0]   c_OFF_CTRL   = 4'hC;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overrun;
  logic          r_data_ready;
  logic [31:0]   r_dev2core_data;
  logic          r_irq_enable;

  logic          w_hit;
  logic          w_rd_rx;
  logic          w_rd_stat;
  logic          w_wr_ctrl;
  logic          w_flush;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovr_set;
  logic [AW:0]   w_count_next;
  logic [31:0]   w_rdata;
  logic          w_unused_bits;

  // Address decode: only the three defined offsets inside the window are hits
  always_comb begin
    w_hit = M_DEVICE_strobe && (M_DEVICE_addr[31:4] == BASE_ADDR[31:4]) &&
            ((M_DEVICE_addr[3:0] == c_OFF_RXDATA) ||
             (M_DEVICE_addr[3:0] == c_OFF_STAT)   ||
             (M_DEVICE_addr[3:0] == c_OFF_CTRL));
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_FULL);
  assign w_rd_rx   = w_hit && !M_DEVICE_rw && (M_DEVICE_addr[3:0] == c_OFF_RXDATA);
  assign w_rd_stat = w_hit && !M_DEVICE_rw && (M_DEVICE_addr[3:0] == c_OFF_STAT);
  assign w_wr_ctrl = w_hit &&  M_DEVICE_rw && (M_DEVICE_addr[3:0] == c_OFF_CTRL) &&
                     M_DEVICE_byte_enable[0];
  assign w_flush   = w_wr_ctrl && M_DEVICE_core2dev_data[1];
  // An empty-FIFO read never pops, so a simultaneous push just enqueues
  assign w_pop     = w_rd_rx && !w_empty;
  // Flush wins over a push: the byte is lost silently, without overrun
  assign w_push    = host_wr && (!w_full || w_pop) && !w_flush;
  assign w_ovr_set = host_wr && w_full && !w_pop && !w_flush;

  // Byte lanes beyond lane 0 and unused data bits carry no meaning here
  assign w_unused_bits = ^{M_DEVICE_byte_enable, M_DEVICE_core2dev_data};

  // Next occupancy from push/pop, collapsing to zero on flush
  always_comb begin
    w_count_next = r_count;
    if (w_flush) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Read-data mux, sampled from state before the current edge
  always_comb begin
    w_rdata = '0;
    if (!M_DEVICE_rw) begin
      case (M_DEVICE_addr[3:0])
        c_OFF_RXDATA: w_rdata = w_empty ? 32'h0 : {24'h0, r_mem[r_rptr]};
        c_OFF_STAT:   w_rdata = {26'h0, r_overrun, 3'b000, w_full, !w_empty};
        c_OFF_CTRL:   w_rdata = {27'h0, r_irq_enable, 4'h0};
        default:      w_rdata = '0;
      endcase
    end
  end

  // FIFO storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= host_data;
    end
  end

  // Bus response, FIFO pointers/count and overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_ready    <= 1'b0;
      r_dev2core_data <= '0;
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_overrun       <= 1'b0;
    end else begin
      r_data_ready    <= w_hit;
      r_dev2core_data <= w_hit ? w_rdata : 32'h0;
      r_count         <= w_count_next;
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (w_rd_stat) begin
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef MOCK_UART_RX_IRQ_EN
  // Interrupt enable register and registered level interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_enable <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_irq_enable <= M_DEVICE_core2dev_data[4];
      irq <= r_irq_enable && !w_empty;
    end
  end
`else
  assign r_irq_enable = 1'b0;
`endif

  assign M_DEVICE_data_ready    = r_data_ready;
  assign M_DEVICE_dev2core_data = r_dev2core_data;

endmodule
`default_nettype wire

// File: tb/tb_mock_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mock_uart_rx
// Description : Directed self-checking bench for mock_uart_rx. Inputs change
//               on the falling edge; outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mock_uart_rx;

  localparam logic [31:0] c_BASE = 32'hC000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_DEVICE_strobe;
  logic [31:0] M_DEVICE_addr;
  logic        M_DEVICE_rw;
  logic [3:0]  M_DEVICE_byte_enable;
  logic [31:0] M_DEVICE_core2dev_data;
  logic        M_DEVICE_data_ready;
  logic [31:0] M_DEVICE_dev2core_data;
  logic        host_wr;
  logic [7:0]  host_data;
`ifdef MOCK_UART_RX_IRQ_EN
  logic        irq;
`endif

  int vectors     = 0;
  int miscompares = 0;

  mock_uart_rx #(.BASE_ADDR(c_BASE), .FIFO_DEPTH(16)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .M_DEVICE_strobe        (M_DEVICE_strobe),
    .M_DEVICE_addr          (M_DEVICE_addr),
    .M_DEVICE_rw            (M_DEVICE_rw),
    .M_DEVICE_byte_enable   (M_DEVICE_byte_enable),
    .M_DEVICE_core2dev_data (M_DEVICE_core2dev_data),
    .M_DEVICE_data_ready    (M_DEVICE_data_ready),
    .M_DEVICE_dev2core_data (M_DEVICE_dev2core_data),
    .host_wr                (host_wr),
    .host_data              (host_data)
`ifdef MOCK_UART_RX_IRQ_EN
    ,
    .irq                    (irq)
`endif
  );

  always #5 clk = ~clk;

  // One bus request from the current falling edge; response sampled one cycle later
  task automatic bus(input logic rw, input logic [3:0] off, input logic [31:0] wd,
                     input logic [3:0] be, output logic rdy, output logic [31:0] rd);
    M_DEVICE_strobe        = 1'b1;
    M_DEVICE_addr          = {c_BASE[31:4], off};
    M_DEVICE_rw            = rw;
    M_DEVICE_byte_enable   = be;
    M_DEVICE_core2dev_data = wd;
    @(negedge clk);
    M_DEVICE_strobe        = 1'b0;
    M_DEVICE_rw            = 1'b0;
    M_DEVICE_core2dev_data = '0;
    rdy = M_DEVICE_data_ready;
    rd  = M_DEVICE_dev2core_data;
  endtask

  task automatic inject(input logic [7:0] b);
    host_wr   = 1'b1;
    host_data = b;
    @(negedge clk);
    host_wr   = 1'b0;
  endtask

  task automatic test_reset();
    logic rdy; logic [31:0] rd;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (M_DEVICE_data_ready !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b want 0", M_DEVICE_data_ready); end
    vectors++; if (M_DEVICE_dev2core_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", M_DEVICE_dev2core_data); end
`ifdef MOCK_UART_RX_IRQ_EN
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
    rst = 1'b0;
    @(negedge clk);
    bus(1'b0, 4'h8, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rdy !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL reset_stat: got rdy=%b %h want rdy=1 0", rdy, rd); end
  endtask

  task automatic test_basic();
    logic rdy; logic [31:0] rd;
    logic [31:0] exp [4] = '{32'h1, 32'h41, 32'h42, 32'h0};
    logic [3:0]  off [4] = '{4'h8, 4'h0, 4'h0, 4'h0};
    inject(8'h41);
    inject(8'h42);
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, off[i], 32'h0, 4'hF, rdy, rd);
      @(negedge clk);
      vectors++; if (rdy !== 1'b1 || rd !== exp[i]) begin miscompares++; $display("FAIL basic_%0d: got rdy=%b %h want rdy=1 %h", i, rdy, rd, exp[i]); end
      vectors++; if (M_DEVICE_data_ready !== 1'b0 || M_DEVICE_dev2core_data !== 32'h0) begin miscompares++; $display("FAIL basic_idle_%0d: got rdy=%b %h want 0 0", i, M_DEVICE_data_ready, M_DEVICE_dev2core_data); end
    end
  endtask

  task automatic test_overrun();
    logic rdy; logic [31:0] rd;
    for (int i = 0; i < 17; i++) inject(8'(i));
    bus(1'b0, 4'h8, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rd !== 32'h23) begin miscompares++; $display("FAIL ovr_stat1: got %h want 23", rd); end
    bus(1'b0, 4'h8, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rd !== 32'h03) begin miscompares++; $display("FAIL ovr_stat2: got %h want 03", rd); end
    for (int i = 0; i < 16; i++) begin
      bus(1'b0, 4'h0, 32'h0, 4'hF, rdy, rd);
      vectors++; if (rdy !== 1'b1 || rd !== 32'(i)) begin miscompares++; $display("FAIL ovr_rx_%0d: got rdy=%b %h want rdy=1 %h", i, rdy, rd, i); end
    end
    bus(1'b0, 4'h8, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL ovr_stat3: got %h want 0", rd); end
  endtask

  task automatic test_full_push_pop();
    logic rdy; logic [31:0] rd;
    for (int i = 0; i < 16; i++) inject(8'hA0 + 8'(i));
    host_wr = 1'b1; host_data = 8'h55;
    bus(1'b0, 4'h0, 32'h0, 4'hF, rdy, rd);
    host_wr = 1'b0;
    vectors++; if (rd !== 32'hA0) begin miscompares++; $display("FAIL fpp_head: got %h want a0", rd); end
    bus(1'b0, 4'h8, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rd !== 32'h03) begin miscompares++; $display("FAIL fpp_stat: got %h want 03", rd); end
    for (int i = 1; i < 17; i++) begin
      bus(1'b0, 4'h0, 32'h0, 4'hF, rdy, rd);
      vectors++; if (rd !== ((i == 16) ? 32'h55 : 32'hA0 + 32'(i))) begin miscompares++; $display("FAIL fpp_rx_%0d: got %h", i, rd); end
    end
  endtask

  task automatic test_empty_push_pop();
    logic rdy; logic [31:0] rd;
    host_wr = 1'b1; host_data = 8'h99;
    bus(1'b0, 4'h0, 32'h0, 4'hF, rdy, rd);
    host_wr = 1'b0;
    vectors++; if (rdy !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL epp_rx: got rdy=%b %h want rdy=1 0", rdy, rd); end
    bus(1'b0, 4'h8, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rd !== 32'h01) begin miscompares++; $display("FAIL epp_stat: got %h want 01", rd); end
    bus(1'b0, 4'h0, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rd !== 32'h99) begin miscompares++; $display("FAIL epp_rx2: got %h want 99", rd); end
  endtask

  task automatic test_overrun_priority();
    logic rdy; logic [31:0] rd;
    for (int i = 0; i < 16; i++) inject(8'(i));
    host_wr = 1'b1; host_data = 8'hEE;
    bus(1'b0, 4'h8, 32'h0, 4'hF, rdy, rd);
    host_wr = 1'b0;
    vectors++; if (rd !== 32'h03) begin miscompares++; $display("FAIL prio_stat1: got %h want 03", rd); end
    bus(1'b0, 4'h8, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rd !== 32'h23) begin miscompares++; $display("FAIL prio_stat2: got %h want 23", rd); end
    bus(1'b0, 4'h8, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rd !== 32'h03) begin miscompares++; $display("FAIL prio_stat3: got %h want 03", rd); end
  endtask

  task automatic test_flush();
    logic rdy; logic [31:0] rd;
    int seen;
    // FIFO still full from the previous scenario: flush with a colliding push
    host_wr = 1'b1; host_data = 8'h77;
    bus(1'b1, 4'hC, 32'h2, 4'hF, rdy, rd);
    host_wr = 1'b0;
    vectors++; if (rdy !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL flush_ack: got rdy=%b %h want rdy=1 0", rdy, rd); end
    bus(1'b0, 4'h8, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL flush_push_stat: got %h want 0", rd); end
    for (int i = 0; i < 3; i++) inject(8'h10 + 8'(i));
    bus(1'b1, 4'hC, 32'h2, 4'hE, rdy, rd);
    bus(1'b1, 4'h0, 32'hFF, 4'hF, rdy, rd);
    vectors++; if (rdy !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL wr_rx_ack: got rdy=%b %h want rdy=1 0", rdy, rd); end
    bus(1'b1, 4'h8, 32'hFF, 4'hF, rdy, rd);
    bus(1'b0, 4'h8, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rd !== 32'h01) begin miscompares++; $display("FAIL noflush_stat: got %h want 01", rd); end
    bus(1'b0, 4'h0, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rd !== 32'h10) begin miscompares++; $display("FAIL noflush_head: got %h want 10", rd); end
    bus(1'b1, 4'hC, 32'h2, 4'h1, rdy, rd);
    bus(1'b0, 4'h8, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL flush_stat: got %h want 0", rd); end
    seen = 0;
    bus(1'b0, 4'h4, 32'h0, 4'hF, rdy, rd);
    if (rdy) seen++;
    bus(1'b0, 4'h0, 32'h0, 4'hF, rdy, rd);
    M_DEVICE_addr = c_BASE + 32'h10;
    M_DEVICE_strobe = 1'b1;
    @(negedge clk);
    M_DEVICE_strobe = 1'b0;
    // The off-window strobe must not respond either
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL hole_next: got rdy=%b want 1", rdy); end
    repeat (4) begin
      if (M_DEVICE_data_ready) seen++;
      @(negedge clk);
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL hole_ignored: got %0d responses want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic rdy1, rdy2; logic [31:0] rd1, rd2;
    inject(8'h11);
    inject(8'h22);
    bus(1'b0, 4'h0, 32'h0, 4'hF, rdy1, rd1);
    bus(1'b0, 4'h0, 32'h0, 4'hF, rdy2, rd2);
    vectors++; if (rdy1 !== 1'b1 || rd1 !== 32'h11) begin miscompares++; $display("FAIL b2b_1: got rdy=%b %h want rdy=1 11", rdy1, rd1); end
    vectors++; if (rdy2 !== 1'b1 || rd2 !== 32'h22) begin miscompares++; $display("FAIL b2b_2: got rdy=%b %h want rdy=1 22", rdy2, rd2); end
  endtask

  task automatic test_ctrl();
    logic rdy; logic [31:0] rd;
    bus(1'b1, 4'hC, 32'h10, 4'hF, rdy, rd);
    bus(1'b0, 4'hC, 32'h0, 4'hF, rdy, rd);
`ifdef MOCK_UART_RX_IRQ_EN
    vectors++; if (rd !== 32'h10) begin miscompares++; $display("FAIL ctrl_rd: got %h want 10", rd); end
    inject(8'h7A);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early: got %b want 0", irq); end
    @(negedge clk);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_set: got %b want 1", irq); end
    bus(1'b0, 4'h0, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rd !== 32'h7A || irq !== 1'b1) begin miscompares++; $display("FAIL irq_pop: got %h irq=%b want 7a irq=1", rd, irq); end
    @(negedge clk);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clr: got %b want 0", irq); end
    bus(1'b1, 4'hC, 32'h0, 4'hF, rdy, rd);
`else
    vectors++; if (rdy !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL ctrl_rd: got rdy=%b %h want rdy=1 0", rdy, rd); end
`endif
  endtask

  task automatic test_reset_inflight();
    logic rdy; logic [31:0] rd;
    int seen = 0;
    inject(8'h33);
    M_DEVICE_strobe = 1'b1;
    M_DEVICE_addr   = {c_BASE[31:4], 4'h8};
    M_DEVICE_rw     = 1'b0;
    @(posedge clk);
    rst = 1'b1;
    M_DEVICE_strobe = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (M_DEVICE_data_ready) seen++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (M_DEVICE_data_ready) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rst_inflight: got %0d responses want 0", seen); end
    bus(1'b0, 4'h8, 32'h0, 4'hF, rdy, rd);
    vectors++; if (rdy !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL rst_stat: got rdy=%b %h want rdy=1 0", rdy, rd); end
  endtask

  initial begin
    rst = 1'b1;
    M_DEVICE_strobe = 1'b0; M_DEVICE_addr = '0; M_DEVICE_rw = 1'b0;
    M_DEVICE_byte_enable = 4'hF; M_DEVICE_core2dev_data = '0;
    host_wr = 1'b0; host_data = '0;
    test_reset();
    test_basic();
    test_overrun();
    test_full_push_pop();
    test_empty_push_pop();
    test_overrun_priority();
    test_flush();
    test_back_to_back();
    test_ctrl();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
